// File: rtl/hazard_pkg.sv
// Shared encodings and the scoreboard entry type for the pipeline hazard controller.
package hazard_pkg;

  localparam int SB_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic             v;
    logic             we;
    logic [SB_AW-1:0] dest;
    logic             ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_dep_cmp.sv
// One scoreboard entry against one ID source operand; r0 never matches.
import hazard_pkg::*;

module hazard_dep_cmp #(
  parameter int REG_AW = 5
) (
  input  sb_entry_t         entry,
  input  logic [REG_AW-1:0] src,
  input  logic              src_use,
  output logic              match
);

  logic unused_ld;
  assign unused_ld = entry.ld;

  assign match = entry.v & entry.we & (entry.dest == SB_AW'(src)) &
                 (src != '0) & src_use;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and flush controller beside the ID stage of the 5-stage pipeline.
// Build option: HAZARD_FWD_EN enables operand forwarding; without it every dependency stalls.
import hazard_pkg::*;

module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_gr_we,
  input  logic              id_is_load,
  input  logic              id_br_taken,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_exe_bubble,
  output logic              br_taken_ok,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // index 0 = EXE, 1 = MEM, 2 = WB
  sb_entry_t  sb [3];
  sb_entry_t  sb_in;
  logic [2:0] m1;
  logic [2:0] m2;
  logic       stall;
  logic       unused_wb_ld;

  assign unused_wb_ld = sb[2].ld;

  for (genvar g = 0; g < 3; g++) begin : g_cmp
    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp1 (
      .entry(sb[g]), .src(id_src1), .src_use(id_use1), .match(m1[g])
    );
    hazard_dep_cmp #(.REG_AW(REG_AW)) u_cmp2 (
      .entry(sb[g]), .src(id_src2), .src_use(id_use2), .match(m2[g])
    );
  end

  always_comb begin
    fwd_sel1 = FWD_RF;
    fwd_sel2 = FWD_RF;
`ifdef HAZARD_FWD_EN
    stall = id_valid & (m1[0] | m2[0]) & sb[0].ld;
    if (m1[0])      fwd_sel1 = FWD_EXE;
    else if (m1[1]) fwd_sel1 = FWD_MEM;
    else if (m1[2]) fwd_sel1 = FWD_WB;
    if (m2[0])      fwd_sel2 = FWD_EXE;
    else if (m2[1]) fwd_sel2 = FWD_MEM;
    else if (m2[2]) fwd_sel2 = FWD_WB;
`else
    // No bypass paths: wait until the producer has retired past WB.
    stall = id_valid & ((|m1) | (|m2));
`endif
  end

  assign br_taken_ok   = id_br_taken & id_valid & ~stall;
  assign pc_we         = ~stall;
  assign if_id_we      = ~stall;
  assign if_id_flush   = br_taken_ok;
  assign id_exe_bubble = stall;

  always_comb begin
    sb_in.v    = id_valid & ~stall;
    sb_in.we   = id_gr_we;
    sb_in.dest = SB_AW'(id_dest);
    sb_in.ld   = id_is_load;
  end

  // The scoreboard never freezes; a stall simply shifts a bubble into EXE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sb[i] <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb[2] <= sb[1];
      sb[1] <= sb[0];
      sb[0] <= sb_in;
      if (stall)       stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_taken_ok) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a distance-based reference model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_use1, id_use2, id_gr_we, id_is_load, id_br_taken;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic        pc_we, if_id_we, if_id_flush, id_exe_bubble, br_taken_ok;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .id_dest(id_dest), .id_gr_we(id_gr_we),
    .id_is_load(id_is_load), .id_br_taken(id_br_taken), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble), .br_taken_ok(br_taken_ok),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: the last three instructions that entered EXE, youngest first.
  typedef struct {
    bit v;
    bit we;
    int dest;
    bit ld;
  } instr_t;

  instr_t      hist [3];
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int distance(input int src, input bit use_it);
    if (!use_it || src == 0) return -1;
    for (int k = 0; k < 3; k++)
      if (hist[k].v && hist[k].we && hist[k].dest == src) return k;
    return -1;
  endfunction

  // One cycle: evaluate the model on the current inputs, check, clock, advance the model.
  task automatic step(output bit stalled);
    int d1, d2;
    bit st, br;
    int s1, s2;
    #1;
    d1 = distance(int'(id_src1), id_use1);
    d2 = distance(int'(id_src2), id_use2);
`ifdef HAZARD_FWD_EN
    st = id_valid && (d1 == 0 || d2 == 0) && hist[0].ld;
    s1 = (d1 < 0) ? 0 : d1 + 1;
    s2 = (d2 < 0) ? 0 : d2 + 1;
`else
    st = id_valid && (d1 >= 0 || d2 >= 0);
    s1 = 0;
    s2 = 0;
`endif
    br = id_br_taken && id_valid && !st;
    chk("pc_we",     32'(pc_we),         32'(!st));
    chk("if_id_we",  32'(if_id_we),      32'(!st));
    chk("bubble",    32'(id_exe_bubble), 32'(st));
    chk("br_ok",     32'(br_taken_ok),   32'(br));
    chk("flush",     32'(if_id_flush),   32'(br));
    chk("fwd_sel1",  32'(fwd_sel1),      32'(s1));
    chk("fwd_sel2",  32'(fwd_sel2),      32'(s2));
    chk("stall_cnt", stall_cnt,          m_stall_cnt);
    chk("flush_cnt", flush_cnt,          m_flush_cnt);
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{id_valid && !st, id_gr_we, int'(id_dest), id_is_load};
      m_stall_cnt += st ? 1 : 0;
      m_flush_cnt += br ? 1 : 0;
    end
    @(negedge clk);
    stalled = st;
  endtask

  task automatic drive(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                       input int d, input bit we, input bit ld, input bit br);
    id_valid = v;   id_src1 = 5'(s1); id_src2 = 5'(s2);
    id_use1 = u1;   id_use2 = u2;     id_dest = 5'(d);
    id_gr_we = we;  id_is_load = ld;  id_br_taken = br;
  endtask

  // Present an instruction and hold it in ID while it stalls.
  task automatic issue(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                       input int d, input bit we, input bit ld, input bit br);
    bit st;
    int n = 0;
    drive(v, s1, s2, u1, u2, d, we, ld, br);
    do begin
      step(st);
      n++;
    end while (st && n < 5);
    if (st) chk("stall_bound", 32'(n), 32'(4));
  endtask

  task automatic bubble_cycles(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    bit st;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(st);
    step(st);
    reset = 1'b0;
  endtask

  initial begin
    bit st;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    do_reset();
    step(st);

    // ALU-ALU: add r4,r1,r2 ; add r5,r4,r3
    issue(1, 1, 2, 1, 1, 4, 1, 0, 0);
    issue(1, 4, 3, 1, 1, 5, 1, 0, 0);
    bubble_cycles(3);

    // Load-use: ld r6 ; add r7,r6,r6
    issue(1, 1, 0, 1, 0, 6, 1, 1, 0);
    issue(1, 6, 6, 1, 1, 7, 1, 0, 0);
    bubble_cycles(3);

    // r0 producer then r0 consumer
    issue(1, 1, 2, 1, 1, 0, 1, 0, 0);
    issue(1, 0, 0, 1, 1, 9, 1, 0, 0);
    bubble_cycles(3);

    // Producer three instructions back
    issue(1, 1, 2, 1, 1, 10, 1, 0, 0);
    issue(1, 1, 2, 1, 1, 11, 1, 0, 0);
    issue(1, 1, 2, 1, 1, 12, 1, 0, 0);
    issue(1, 10, 3, 1, 1, 13, 1, 0, 0);
    bubble_cycles(3);

    // ld r8 ; beq r8,r9 taken
    issue(1, 1, 0, 1, 0, 8, 1, 1, 0);
    issue(1, 8, 9, 1, 1, 0, 0, 0, 1);
    bubble_cycles(3);

    // Reset asserted during a load-use stall
    issue(1, 1, 0, 1, 0, 6, 1, 1, 0);
    drive(1, 6, 6, 1, 1, 7, 1, 0, 0);
    reset = 1'b1;
    step(st);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(st);
    chk("post_reset_stall_cnt", stall_cnt, 32'd0);
    chk("post_reset_pc_we", 32'(pc_we), 32'd1);

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(99) < 85, int'($urandom_range(7)), int'($urandom_range(7)),
            1'($urandom), 1'($urandom), int'($urandom_range(7)),
            $urandom_range(99) < 80, $urandom_range(99) < 30, $urandom_range(99) < 20);
    end
    bubble_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall/flush controller for the 5-stage in-order pipeline (IF, ID, EXE, MEM, WB).
- Keeps its own shadow scoreboard of the destination registers in flight in EXE, MEM and WB.
- From that scoreboard it drives:
  - forwarding selects for the ID-stage operands;
  - load-use stalls;
  - IF/ID flush on branches taken in ID;
  - bubble insertion into ID/EXE.
- Sits beside the ID stage. Outputs go to the PC enable, the IF/ID and ID/EXE register enables/flushes, and the ID operand muxes.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_AW  rj index
- id_src2  in  REG_AW  rk, or rd for beq/bne/st.w
- id_use1  in  1  instruction reads src1
- id_use2  in  1  instruction reads src2
- id_dest  in  REG_AW  destination (rd, or 1 for bl)
- id_gr_we  in  1  instruction writes the regfile
- id_is_load  in  1  ld.w
- id_br_taken  in  1  raw branch decision from the ID compare
- pc_we  out  1  PC register enable
- if_id_we  out  1  IF/ID enable
- if_id_flush  out  1  clear IF/ID to a bubble
- id_exe_bubble  out  1  load a bubble into ID/EXE
- br_taken_ok  out  1  qualified branch-taken, drives nPC
- fwd_sel1  out  2  src1 source: 0 regfile, 1 EXE alu_result, 2 MEM final_result, 3 WB rf_wdata
- fwd_sel2  out  2  src2 source, same encoding
- stall_cnt  out  CNT_W  cycles stalled
- flush_cnt  out  CNT_W  IF/ID flushes

Behaviour:
- **Scoreboard.** Three registered entries {v, we, dest, ld}, one each for EXE, MEM and WB.
  - Each cycle: WB<=MEM, MEM<=EXE.
  - EXE <= {id_valid & ~stall, id_gr_we, id_dest, id_is_load}. A stall therefore shifts in a bubble.
  - The scoreboard never freezes: EXE, MEM and WB always advance.
- **Match rule.** match_s(x) = v_x & we_x & (dest_x == src) & (src != 0) & use. r0 never matches.
- **Forward priority.** EXE > MEM > WB > regfile, i.e. the youngest producer wins.
- **Load-use stall.** stall = id_valid & (match_EXE(src1) | match_EXE(src2)) & ld_EXE.
  - Stall lasts exactly 1 cycle. Next cycle the load is in MEM and is forwarded with sel 2.
- **While stalled:**
  - pc_we=0, if_id_we=0, id_exe_bubble=1.
  - br_taken_ok=0, because the branch operands are stale.
  - if_id_flush=0.
- **Branch.** br_taken_ok = id_br_taken & id_valid & ~stall.
  - When br_taken_ok=1: if_id_flush=1 in the same cycle, and pc_we=1.
  - Flush takes priority over if_id_we for the IF/ID contents.
- **Stall and branch in the same cycle.** Stall wins; the branch re-evaluates next cycle with forwarded data.
- **Defaults** (no hazard): pc_we=1, if_id_we=1, flush=0, bubble=0, sel=0.
- **Outputs are combinational from registered scoreboard state plus ID inputs.** Counters are registered.
- **Counters.** Increment by 1 on stall / on flush, and wrap modulo 2^CNT_W.
- **Reset.**
  - All scoreboard v=0, both counters=0.
  - Combinational outputs settle to their defaults, with br_taken_ok=0 since id_valid=0.
  - Reset mid-stall drops the pending stall on the next edge.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- **Defined:** forwarding as described above.
- **Undefined:**
  - fwd_sel1 and fwd_sel2 are tied to 0.
  - stall = id_valid & any match in EXE, MEM or WB, regardless of ld.
  - The stall repeats until no match remains, up to 3 cycles.
  - Branch and flush gating are unchanged.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'd0, FWD_EXE=2'd1, FWD_MEM=2'd2, FWD_WB=2'd3;
  - the scoreboard entry struct typedef sb_entry_t.
- Sub-module hazard_dep_cmp is instantiated six times (3 stages x 2 sources).
  - Inputs: an entry, src and use.
  - Output: the match bit.

Test Plan:
- **ALU-ALU forward.** add.w r4,r1,r2 then add.w r5,r4,r3 back-to-back -> second instruction in ID sees fwd_sel1=1, stall=0, stall_cnt unchanged.
- **Load-use.** ld.w r6,... then add.w r7,r6,r6 -> one cycle with pc_we=0, if_id_we=0, id_exe_bubble=1; next cycle fwd_sel1=fwd_sel2=2; stall_cnt=1.
- **r0 and distance.**
  - add.w r0,... then use of r0 -> sel=0, no stall.
  - Producer three instructions back -> sel=3.
- **Branch with dependency.** ld.w r8 then beq r8,r9 with id_br_taken=1 -> stall cycle has br_taken_ok=0, flush=0; next cycle br_taken_ok=1, if_id_flush=1, flush_cnt=1.
- **Without HAZARD_FWD_EN.** addi.w r4 then add.w using r4 -> 3 stall cycles, sel always 0, stall_cnt=3.
- **Reset mid-stall.** Assert reset during a load-use stall -> next cycle counters=0, all outputs at defaults, no spurious stall.
